// File: rtl/rv32_pkg.sv
// Shared definitions for the multi-cycle RV32I/RV32E core: opcode and funct3
// encodings, FSM state encoding, ALU operations and immediate formats.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_TRAP} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  // Sign-extended immediate of the requested format
  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_sel_e sel);
    case (sel)
      IMM_I:   return {{20{ir[31]}}, ir[31:20]};
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  // Register/immediate arithmetic op from funct3; alt selects SUB/SRA
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational ALU for the multi-cycle core, plus comparison flags for branches.
module rv32_alu
  import rv32_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  // Operation select; shift amounts use b[4:0]
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, lt};
      ALU_SLTU: result = {31'b0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> (MEM ->) FETCH, with a terminal
// TRAP state. Optional macro MISALIGN_TRAP_EN turns misaligned halfword/word
// accesses and misaligned taken branch/jump targets into traps.
module rv32i_multicycle_core
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ireq,
  input  logic        iready,
  input  logic [31:0] idata,
  output logic [31:0] daddr,
  output logic        dreq,
  input  logic        dready,
  input  logic [31:0] drdata,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  output logic        trap
);

  localparam int unsigned RW      = $clog2(NREGS);
  localparam logic [5:0]  NREGS_L = 6'(NREGS);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regs [NREGS];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1v, rs2v, pc4;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  assign pc4    = pc + 32'd4;
  assign iaddr  = pc;

  assign rs1v = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
  assign rs2v = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        eq, lt, ltu;

  rv32_alu u_alu (
    .op     (alu_op),
    .a      (rs1v),
    .b      (alu_b),
    .result (alu_y),
    .eq     (eq),
    .lt     (lt),
    .ltu    (ltu)
  );

  logic        illegal, is_load, is_store, wb_en, take;
  logic        use_rd, use_rs1, use_rs2, bad_reg, misalign, trap_now;
  logic [31:0] wb_val, tgt, next_pc;

  // Instruction decode, writeback value and control-flow target
  always_comb begin
    illegal  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    wb_en    = 1'b0;
    wb_val   = alu_y;
    alu_op   = ALU_ADD;
    alu_b    = imm_gen(ir, IMM_I);
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    take     = 1'b0;
    tgt      = pc4;
    case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1; wb_en = 1'b1; wb_val = imm_gen(ir, IMM_U);
      end
      OPC_AUIPC: begin
        use_rd = 1'b1; wb_en = 1'b1; wb_val = pc + imm_gen(ir, IMM_U);
      end
      OPC_JAL: begin
        use_rd = 1'b1; wb_en = 1'b1; wb_val = pc4;
        take = 1'b1; tgt = pc + imm_gen(ir, IMM_J);
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wb_en = 1'b1; wb_val = pc4;
        take = 1'b1; tgt = {alu_y[31:1], 1'b0};
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        alu_b = rs2v; alu_op = ALU_SUB;
        tgt = pc + imm_gen(ir, IMM_B);
        case (f3)
          F3_BEQ:  take = eq;
          F3_BNE:  take = !eq;
          F3_BLT:  take = lt;
          F3_BGE:  take = !lt;
          F3_BLTU: take = ltu;
          F3_BGEU: take = !ltu;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; is_load = 1'b1;
        case (f3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
        alu_b = imm_gen(ir, IMM_S);
        case (f3)
          F3_SB, F3_SH, F3_SW: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wb_en = 1'b1;
        alu_op = alu_from_f3(f3, ir[30] && (f3 == 3'b101));
        if (f3 == 3'b001 && f7 != 7'b0000000)
          illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
          illegal = 1'b1;
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wb_en = 1'b1;
        alu_b = rs2v; alu_op = alu_from_f3(f3, ir[30]);
        illegal = !((f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_FENCE: illegal = (f3 != 3'b000);
      default:   illegal = 1'b1;
    endcase
  end

  // Register indices beyond the implemented file (RV32E) are illegal
  always_comb begin
    bad_reg = (use_rd  && ({1'b0, rd}  >= NREGS_L)) ||
              (use_rs1 && ({1'b0, rs1} >= NREGS_L)) ||
              (use_rs2 && ({1'b0, rs2} >= NREGS_L));
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned targets and accesses trap; halfword/word funct3 codes are shared by loads and stores
  always_comb begin
    misalign = take && (tgt[1:0] != 2'b00);
    if (is_load || is_store) begin
      case (f3)
        F3_LH, F3_LHU: misalign = alu_y[0];
        F3_LW:         misalign = (alu_y[1:0] != 2'b00);
        default:       misalign = 1'b0;
      endcase
    end
    next_pc = take ? tgt : pc4;
  end
`else
  // Misalignment ignored: taken targets are forced to a word boundary
  always_comb begin
    misalign = 1'b0;
    next_pc  = take ? (tgt & ~32'd3) : pc4;
  end
`endif

  assign trap_now = illegal || bad_reg || misalign;

  logic [3:0]  st_we;
  logic [31:0] st_data;

  // Store lane enables and replicated write data
  always_comb begin
    st_we   = '0;
    st_data = '0;
    if (is_store) begin
      case (f3)
        F3_SB: begin
          st_we = 4'b0001 << alu_y[1:0]; st_data = {4{rs2v[7:0]}};
        end
        F3_SH: begin
          st_we = alu_y[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2v[15:0]}};
        end
        default: begin
          st_we = 4'b1111; st_data = rs2v;
        end
      endcase
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Load lane extraction and sign/zero extension
  always_comb begin
    case (daddr[1:0])
      2'd0:    ld_byte = drdata[7:0];
      2'd1:    ld_byte = drdata[15:8];
      2'd2:    ld_byte = drdata[23:16];
      default: ld_byte = drdata[31:24];
    endcase
    ld_half = daddr[1] ? drdata[31:16] : drdata[15:0];
    case (f3)
      F3_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_val = {24'b0, ld_byte};
      F3_LHU:  ld_val = {16'b0, ld_half};
      default: ld_val = drdata;
    endcase
  end

  // Control FSM with registered bus outputs and register-file writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      ireq   <= 1'b0;
      dreq   <= 1'b0;
      daddr  <= '0;
      dwdata <= '0;
      dwe    <= '0;
      trap   <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i[RW-1:0]] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          // ireq only starts low straight out of reset; EXEC/MEM raise it on return
          if (!ireq) begin
            ireq <= 1'b1;
          end else if (iready) begin
            ir    <= idata;
            ireq  <= 1'b0;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (trap_now) begin
            trap  <= 1'b1;
            ireq  <= 1'b0;
            dreq  <= 1'b0;
            state <= ST_TRAP;
          end else if (is_load || is_store) begin
            daddr  <= alu_y;
            dwe    <= st_we;
            dwdata <= st_data;
            dreq   <= 1'b1;
            state  <= ST_MEM;
          end else begin
            if (wb_en && rd != 5'd0)
              regs[rd[RW-1:0]] <= wb_val;
            pc    <= next_pc;
            ireq  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dready) begin
            if (is_load && rd != 5'd0)
              regs[rd[RW-1:0]] <= ld_val;
            pc    <= pc4;
            dreq  <= 1'b0;
            ireq  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        default: begin
          ireq <= 1'b0;
          dreq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Self-checking bench for rv32i_multicycle_core: a small program in an
// instruction ROM model, a byte-lane data RAM model, and scoreboards of
// expected fetch addresses and data-bus transactions.
module tb_rv32i_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iaddr, idata, daddr, drdata, dwdata;
  logic        ireq, iready, dreq, dready, trap;
  logic [3:0]  dwe;

  rv32i_multicycle_core #(
    .RESET_PC (32'h0000_0000),
    .NREGS    (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .iaddr  (iaddr),
    .ireq   (ireq),
    .iready (iready),
    .idata  (idata),
    .daddr  (daddr),
    .dreq   (dreq),
    .dready (dready),
    .drdata (drdata),
    .dwdata (dwdata),
    .dwe    (dwe),
    .trap   (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    int unsigned delay;
  } dexp_t;

  logic [31:0] imem [256];
  logic [31:0] dmem [16];
  logic [31:0] exp_pc [$];
  dexp_t       exp_d [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        live;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LDO = 7'b0000011;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [11:0] i;
    i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), f3, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), f3, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] i;
    i = 21'(imm);
    return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  // Place an instruction and, while the program is still expected to run, expect its fetch
  task automatic ins(input logic [31:0] addr, input logic [31:0] word);
    imem[addr[9:2]] = word;
    if (live) exp_pc.push_back(addr);
  endtask

  task automatic exp_mem(input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] data, input int unsigned delay);
    dexp_t e;
    e.addr = addr; e.we = we; e.data = data; e.delay = delay;
    if (live) exp_d.push_back(e);
  endtask

  logic [31:0] trap_pc, e_pc;
  dexp_t       cur;
  logic        dreq_q, done, found;
  int unsigned dcnt;
  int          last_cyc;

  initial begin
    reset  = 1'b1;
    iready = 1'b1;
    idata  = '0;
    dready = 1'b0;
    drdata = '0;
    for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++)  dmem[i] = '0;
    live = 1'b1;

    ins(32'h00, enc_i(-5, 0, 3'b000, 1, OPI));                 // ADDI  x1,x0,-5
    ins(32'h04, enc_i(1, 1, 3'b011, 2, OPI));                  // SLTIU x2,x1,1
    ins(32'h08, enc_s(0, 1, 0, 3'b010));  exp_mem(0, 4'hF, 32'hFFFF_FFFB, 0);
    ins(32'h0C, enc_s(4, 2, 0, 3'b010));  exp_mem(4, 4'hF, 32'h0, 0);
    ins(32'h10, enc_i(1, 0, 3'b000, 3, LDO)); exp_mem(1, 4'h0, 32'h0, 0);   // LB  x3
    ins(32'h14, enc_i(1, 0, 3'b100, 4, LDO)); exp_mem(1, 4'h0, 32'h0, 0);   // LBU x4
    ins(32'h18, enc_s(8, 3, 0, 3'b010));  exp_mem(8, 4'hF, 32'hFFFF_FFFF, 0);
    ins(32'h1C, enc_s(12, 4, 0, 3'b010)); exp_mem(12, 4'hF, 32'h0000_00FF, 0);
    ins(32'h20, enc_i(165, 0, 3'b000, 5, OPI));                // x5 = 0xA5
    ins(32'h24, enc_s(6, 5, 0, 3'b000));  exp_mem(6, 4'b0100, 32'hA5A5_A5A5, 3);
    ins(32'h28, enc_s(2, 1, 0, 3'b001));  exp_mem(2, 4'b1100, 32'hFFFB_FFFB, 1);
    ins(32'h2C, enc_i(6, 0, 3'b001, 6, LDO)); exp_mem(6, 4'h0, 32'h0, 0);   // LH  x6
    ins(32'h30, enc_s(16, 6, 0, 3'b010)); exp_mem(16, 4'hF, 32'h0000_00A5, 0);
    ins(32'h34, enc_i(2, 0, 3'b101, 7, LDO)); exp_mem(2, 4'h0, 32'h0, 2);   // LHU x7
    ins(32'h38, enc_s(20, 7, 0, 3'b010)); exp_mem(20, 4'hF, 32'h0000_FFFB, 0);
    ins(32'h3C, enc_b(8, 0, 1, 3'b001));                       // BNE taken  -> 0x44
    ins(32'h44, enc_b(8, 0, 1, 3'b000));                       // BEQ not taken
    ins(32'h48, enc_b(12, 0, 1, 3'b100));                      // BLT taken  -> 0x54
    ins(32'h54, enc_b(8, 0, 1, 3'b110));                       // BLTU not taken
    ins(32'h58, enc_j(8, 9));                                  // JAL x9 -> 0x60
    ins(32'h60, enc_s(24, 9, 0, 3'b010)); exp_mem(24, 4'hF, 32'h0000_005C, 0);
    ins(32'h64, enc_i(2, 0, 3'b010, 8, LDO));                  // LW x8,2(x0)
`ifdef MISALIGN_TRAP_EN
    live = 1'b0;
`else
    exp_mem(2, 4'h0, 32'h0, 0);
`endif
    ins(32'h68, enc_s(28, 8, 0, 3'b010)); exp_mem(28, 4'hF, 32'hFFFB_FFFB, 0);
    ins(32'h6C, enc_i(7, 0, 3'b000, 0, OPI));                  // write to x0 discarded
    ins(32'h70, enc_s(36, 0, 0, 3'b010)); exp_mem(36, 4'hF, 32'h0, 0);
    ins(32'h74, enc_i(256, 0, 3'b000, 2, OPI));                // x2 = 0x100
    ins(32'h78, enc_i(3, 2, 3'b000, 1, 7'b1100111));           // JALR x1,3(x2): 0x103 -> 0x100
    ins(32'h100, enc_s(32, 1, 0, 3'b010)); exp_mem(32, 4'hF, 32'h0000_007C, 0);
    ins(32'h104, enc_r(7'b0100000, 1, 0, 3'b000, 10));         // SUB  x10 = -0x7C
    ins(32'h108, enc_i(32'h404, 10, 3'b101, 11, OPI));         // SRAI x11,x10,4
    ins(32'h10C, enc_i(28, 10, 3'b101, 12, OPI));              // SRLI x12,x10,28
    ins(32'h110, enc_s(40, 11, 0, 3'b010)); exp_mem(40, 4'hF, 32'hFFFF_FFF8, 0);
    ins(32'h114, enc_s(44, 12, 0, 3'b010)); exp_mem(44, 4'hF, 32'h0000_000F, 0);
    ins(32'h118, 32'hFFFF_FFFF);                               // illegal word
`ifdef MISALIGN_TRAP_EN
    trap_pc = 32'h64;
`else
    trap_pc = 32'h118;
`endif

    #1;
    check_eq("rst_iaddr", iaddr, 32'h0);
    check_eq("rst_ireq", 32'(ireq), 32'h0);
    check_eq("rst_dreq", 32'(dreq), 32'h0);
    check_eq("rst_dwe", 32'(dwe), 32'h0);
    check_eq("rst_trap", 32'(trap), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    dreq_q = 1'b0; done = 1'b0; dcnt = 0; last_cyc = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (trap) begin
        check_eq("trap_pc", iaddr, trap_pc);
        check_eq("trap_ireq", 32'(ireq), 32'h0);
        done = 1'b1;
      end else begin
        if (ireq) begin
          // Unaligned sentinel: any surplus fetch is reported
          e_pc = (exp_pc.size() != 0) ? exp_pc.pop_front() : 32'hFFFF_FFFF;
          check_eq("fetch_pc", iaddr, e_pc);
          if (iaddr == 32'h04) check_eq("alu_latency", 32'(c - last_cyc), 32'd2);
          if (iaddr == 32'h0C) check_eq("store_latency", 32'(c - last_cyc), 32'd3);
          last_cyc = c;
        end
        idata = imem[iaddr[9:2]];
        if (dreq) begin
          if (!dreq_q) begin
            if (exp_d.size() != 0) cur = exp_d.pop_front();
            else cur = '{addr: 32'hFFFF_FFFF, we: 4'hF, data: 32'h0, delay: 0};
            dcnt = 0;
          end
          check_eq("daddr", daddr, cur.addr);
          check_eq("dwe", 32'(dwe), 32'(cur.we));
          if (cur.we != 4'h0) check_eq("dwdata", dwdata, cur.data);
          drdata = dmem[daddr[5:2]];
          dready = (dcnt >= cur.delay);
          if (dready)
            for (int l = 0; l < 4; l++)
              if (dwe[l]) dmem[daddr[5:2]][8*l +: 8] = dwdata[8*l +: 8];
          dcnt++;
        end else begin
          dready = c[0];   // toggling outside a request must be ignored
        end
        dreq_q = dreq;
      end
    end
    check_eq("trap_reached", 32'(trap), 32'h1);
    dready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("halt_ireq", 32'(ireq), 32'h0);
    check_eq("halt_dreq", 32'(dreq), 32'h0);
    check_eq("halt_trap", 32'(trap), 32'h1);
    check_eq("fetch_q_left", 32'(exp_pc.size()), 32'h0);
    check_eq("data_q_left", 32'(exp_d.size()), 32'h0);

    // Reset out of the trap, then again in the middle of a data handshake
    #2 reset = 1'b1;
    #1;
    check_eq("rst2_trap", 32'(trap), 32'h0);
    check_eq("rst2_iaddr", iaddr, 32'h0);
    check_eq("rst2_ireq", 32'(ireq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      idata  = imem[iaddr[9:2]];
      dready = 1'b0;
      if (dreq) found = 1'b1;
    end
    check_eq("p2_dreq", 32'(dreq), 32'h1);
    check_eq("p2_dwdata", dwdata, 32'hFFFF_FFFB);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_dreq", 32'(dreq), 32'h0);
    check_eq("midrst_dwe", 32'(dwe), 32'h0);
    check_eq("midrst_dwdata", dwdata, 32'h0);
    check_eq("midrst_iaddr", iaddr, 32'h0);
    #10 reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
